// File: rtl/wb_stage_pipe_pkg.sv
// Shared encodings for the pipelined write-back stage: source selects, load types, FSM states.
package wb_stage_pipe_pkg;

    localparam logic [1:0] RFW_ALUC = 2'd0;
    localparam logic [1:0] RFW_DRAM = 2'd1;
    localparam logic [1:0] RFW_SEXT = 2'd2;
    localparam logic [1:0] RFW_NPC  = 2'd3;

    localparam logic RFWR_N = 1'b0;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: picks the byte/half lane from an aligned DRAM word and
// sign- or zero-extends it to XLEN. Unknown load types pass the full word through.
module wb_load_align
    import wb_stage_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_ld_type,
    input  logic [1:0]      i_addr_lo,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_ld_type)
            LD_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LD_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
            LD_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
            LD_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Pipelined write-back stage: valid/ready intake from MEM, source mux, DRAM load wait,
// registered RF write port, load-pending hazard flag and retire counter.
module wb_stage_pipe
    import wb_stage_pipe_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned LINK_REG = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_aluc,
    input  logic [XLEN-1:0]  in_pc4,
    input  logic [XLEN-1:0]  in_ext,
    input  logic             in_wen,
    input  logic             in_rf_wrsel,
    input  logic [1:0]       in_rf_wsel,
    input  logic [2:0]       in_ld_type,
    input  logic [1:0]       in_addr_lo,
    input  logic             dram_rvalid,
    input  logic [XLEN-1:0]  dram_rdata,
    input  logic             flush,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_wr,
    output logic [XLEN-1:0]  rf_wd,
    output logic             ld_pending,
    output logic [RA_W-1:0]  ld_rd,
    output logic             retire,
    output logic [CNT_W-1:0] ret_cnt
);

    wb_state_e        r_state;
    wb_state_e        w_state_d;
    logic             r_rf_we;
    logic [RA_W-1:0]  r_rf_wr;
    logic [XLEN-1:0]  r_rf_wd;
    logic             r_retire;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [RA_W-1:0]  r_ld_rd;
    logic [2:0]       r_ld_type;
    logic [1:0]       r_addr_lo;
    logic             r_ld_wen;

    logic             w_xfer;
    logic [RA_W-1:0]  w_rd;
    logic [XLEN-1:0]  w_src;
    logic [XLEN-1:0]  w_ld_data;
    logic             w_retire;
    logic             w_we;
    logic [RA_W-1:0]  w_wr;
    logic [XLEN-1:0]  w_wd;
    logic             w_latch;
    logic             w_unused_inst;

    assign w_unused_inst = ^in_inst[31:RA_W];

    // flush has priority over in_valid, so a flushed instruction never transfers
    assign w_xfer = in_valid & in_ready & ~flush;
    assign w_rd   = (in_rf_wrsel == RFWR_N) ? in_inst[RA_W-1:0] : RA_W'(LINK_REG);

    always_comb begin
        case (in_rf_wsel)
            RFW_ALUC: w_src = in_aluc;
            RFW_SEXT: w_src = in_ext;
            RFW_NPC:  w_src = in_pc4;
            default:  w_src = '0;
        endcase
    end

    wb_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_rdata   (dram_rdata),
        .i_ld_type (r_ld_type),
        .i_addr_lo (r_addr_lo),
        .o_data    (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            S_IDLE: if (w_latch) w_state_d = S_WAIT;
            S_WAIT: if (flush || dram_rvalid) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (r_state == S_IDLE);
        ld_pending = (r_state == S_WAIT);
        ld_rd      = ld_pending ? r_ld_rd : '0;
        w_retire   = 1'b0;
        w_we       = 1'b0;
        w_wr       = r_rf_wr;
        w_wd       = r_rf_wd;
        w_latch    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (in_rf_wsel == RFW_DRAM) begin
                        w_latch = 1'b1;
                    end else begin
                        w_retire = 1'b1;
                        w_we     = in_wen & (w_rd != '0);
                        w_wr     = w_rd;
                        w_wd     = w_src;
                    end
                end
            end
            S_WAIT: begin
                // a flush in the same cycle as the read data discards the load
                if (!flush && dram_rvalid) begin
                    w_retire = 1'b1;
                    w_we     = r_ld_wen & (r_ld_rd != '0);
                    w_wr     = r_ld_rd;
                    w_wd     = w_ld_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_wr   <= '0;
            r_rf_wd   <= '0;
            r_retire  <= 1'b0;
            r_ret_cnt <= '0;
            r_ld_rd   <= '0;
            r_ld_type <= LD_W;
            r_addr_lo <= '0;
            r_ld_wen  <= 1'b0;
        end else begin
            r_rf_we  <= w_we;
            r_retire <= w_retire;
            if (w_we) begin
                r_rf_wr <= w_wr;
                r_rf_wd <= w_wd;
            end
            if (w_retire) begin
                r_ret_cnt <= r_ret_cnt + CNT_W'(1);
            end
            if (w_latch) begin
                r_ld_rd   <= w_rd;
                r_ld_type <= in_ld_type;
                r_addr_lo <= in_addr_lo;
                r_ld_wen  <= in_wen;
            end
        end
    end

    assign rf_we   = r_rf_we;
    assign rf_wr   = r_rf_wr;
    assign rf_wd   = r_rf_wd;
    assign retire  = r_retire;
    assign ret_cnt = r_ret_cnt;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: behavioural model compared every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_wb_stage_pipe;
    import wb_stage_pipe_pkg::*;

    logic        clk, rst_n;
    logic        in_valid, in_wen, in_rf_wrsel, dram_rvalid, flush;
    logic [31:0] in_inst, in_aluc, in_pc4, in_ext, dram_rdata;
    logic [1:0]  in_rf_wsel, in_addr_lo;
    logic [2:0]  in_ld_type;

    logic        in_ready, rf_we, ld_pending, retire;
    logic [4:0]  rf_wr, ld_rd;
    logic [31:0] rf_wd, ret_cnt;
    logic        in_ready4, rf_we4, ld_pending4, retire4;
    logic [4:0]  rf_wr4, ld_rd4;
    logic [31:0] rf_wd4;
    logic [3:0]  ret_cnt4;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    wb_stage_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_aluc(in_aluc), .in_pc4(in_pc4), .in_ext(in_ext),
        .in_wen(in_wen), .in_rf_wrsel(in_rf_wrsel), .in_rf_wsel(in_rf_wsel),
        .in_ld_type(in_ld_type), .in_addr_lo(in_addr_lo), .dram_rvalid(dram_rvalid),
        .dram_rdata(dram_rdata), .flush(flush), .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
        .ld_pending(ld_pending), .ld_rd(ld_rd), .retire(retire), .ret_cnt(ret_cnt)
    );

    wb_stage_pipe #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_inst(in_inst), .in_aluc(in_aluc), .in_pc4(in_pc4), .in_ext(in_ext),
        .in_wen(in_wen), .in_rf_wrsel(in_rf_wrsel), .in_rf_wsel(in_rf_wsel),
        .in_ld_type(in_ld_type), .in_addr_lo(in_addr_lo), .dram_rvalid(dram_rvalid),
        .dram_rdata(dram_rdata), .flush(flush), .rf_we(rf_we4), .rf_wr(rf_wr4), .rf_wd(rf_wd4),
        .ld_pending(ld_pending4), .ld_rd(ld_rd4), .retire(retire4), .ret_cnt(ret_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: what the stage must do, from the behavioural rules
    logic        m_wait, m_we, m_ret, m_ld_wen;
    logic [4:0]  m_wr, m_ld_rd;
    logic [31:0] m_wd, m_cnt;
    logic [2:0]  m_ld_t;
    logic [1:0]  m_lo;
    logic [4:0]  m_dest;

    assign m_dest = (in_rf_wrsel == RFWR_N) ? in_inst[4:0] : 5'd1;

    function automatic logic [31:0] m_src(input logic [1:0] sel);
        case (sel)
            RFW_ALUC: return in_aluc;
            RFW_SEXT: return in_ext;
            RFW_NPC:  return in_pc4;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] t,
                                          input logic [1:0] lo);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * lo[1])) & 32'hFFFF;
        case (t)
            LD_B:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            LD_BU:   return b;
            LD_H:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            LD_HU:   return h;
            default: return w;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait <= 0; m_we <= 0; m_ret <= 0; m_wr <= 0; m_wd <= 0; m_cnt <= 0;
            m_ld_rd <= 0; m_ld_t <= 0; m_lo <= 0; m_ld_wen <= 0;
        end else begin
            m_we  <= 0;
            m_ret <= 0;
            if (!m_wait) begin
                if (in_valid && !flush) begin
                    if (in_rf_wsel == RFW_DRAM) begin
                        m_wait <= 1; m_ld_rd <= m_dest; m_ld_t <= in_ld_type;
                        m_lo <= in_addr_lo; m_ld_wen <= in_wen;
                    end else begin
                        m_ret <= 1; m_cnt <= m_cnt + 1;
                        if (in_wen && m_dest != 0) begin
                            m_we <= 1; m_wr <= m_dest; m_wd <= m_src(in_rf_wsel);
                        end
                    end
                end
            end else if (flush) begin
                m_wait <= 0;
            end else if (dram_rvalid) begin
                m_wait <= 0; m_ret <= 1; m_cnt <= m_cnt + 1;
                if (m_ld_wen && m_ld_rd != 0) begin
                    m_we <= 1; m_wr <= m_ld_rd; m_wd <= m_ext(dram_rdata, m_ld_t, m_lo);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_rf_we", rf_we, m_we);
            chk("cyc_rf_wr", rf_wr, m_wr);
            chk("cyc_rf_wd", rf_wd, m_wd);
            chk("cyc_retire", retire, m_ret);
            chk("cyc_ret_cnt", ret_cnt, m_cnt);
            chk("cyc_in_ready", in_ready, !m_wait);
            chk("cyc_ld_pending", ld_pending, m_wait);
            chk("cyc_ld_rd", ld_rd, m_wait ? m_ld_rd : 5'd0);
            chk("cyc4_ret_cnt", ret_cnt4, m_cnt[3:0]);
            chk("cyc4_rf_we", rf_we4, m_we);
            chk("cyc4_rf_wr", rf_wr4, m_wr);
            chk("cyc4_rf_wd", rf_wd4, m_wd);
            chk("cyc4_retire", retire4, m_ret);
            chk("cyc4_in_ready", in_ready4, !m_wait);
            chk("cyc4_ld_pending", ld_pending4, m_wait);
            chk("cyc4_ld_rd", ld_rd4, m_wait ? m_ld_rd : 5'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = 0; flush = 0; dram_rvalid = 0;
    endtask

    task automatic set_op(input logic [4:0] rd, input logic [1:0] wsel, input logic [31:0] v);
        in_valid = 1; in_inst = 32'hABCD_0000 | {27'd0, rd}; in_wen = 1;
        in_rf_wrsel = RFWR_N; in_rf_wsel = wsel;
        in_aluc = v; in_ext = ~v; in_pc4 = v + 32'd4;
    endtask

    task automatic do_load(input logic [2:0] t, input logic [1:0] lo, input logic [4:0] rd,
                           input logic [31:0] word, input logic [31:0] exp);
        set_op(rd, RFW_DRAM, 32'h5555);
        in_ld_type = t; in_addr_lo = lo;
        cyc();
        clr();
        for (int i = 0; i < 3; i++) begin
            chk("ld_pending", ld_pending, 1'b1);
            chk("ld_rd", ld_rd, rd);
            chk("ld_in_ready", in_ready, 1'b0);
            chk("ld_no_we", rf_we, 1'b0);
            if (i == 0) set_op(5'd3, RFW_ALUC, 32'h77);
            else in_valid = 0;
            if (i == 2) begin dram_rvalid = 1; dram_rdata = word; end
            cyc();
        end
        clr();
        chk("ld_wd", rf_wd, exp);
        chk("ld_we", rf_we, 1'b1);
        chk("ld_wr", rf_wr, rd);
        chk("ld_done", ld_pending, 1'b0);
    endtask

    logic [2:0]  lt [7] = '{LD_B, LD_HU, LD_H, LD_BU, LD_W, 3'd7, LD_B};
    logic [1:0]  llo[7] = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd1};
    logic [4:0]  lrd[7] = '{5'd7, 5'd8, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    logic [31:0] lw [7] = '{32'h0080FF00, 32'h0080FF00, 32'h12348001, 32'hAB000000,
                            32'hCAFEF00D, 32'h11223344, 32'h00007F00};
    logic [31:0] lx [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h000000AB,
                            32'hCAFEF00D, 32'h11223344, 32'h0000007F};

    initial begin
        rst_n = 0; clr(); in_inst = 0; in_aluc = 0; in_pc4 = 0; in_ext = 0; in_wen = 0;
        in_rf_wrsel = 0; in_rf_wsel = 0; in_ld_type = 0; in_addr_lo = 0; dram_rdata = 0;
        cyc(); cyc();
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_ret_cnt", ret_cnt, 32'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1; chk_on = 1;
        cyc();

        set_op(5'd5, RFW_ALUC, 32'h1234);
        cyc(); clr();
        chk("t1_we", rf_we, 1'b1); chk("t1_wr", rf_wr, 5'd5); chk("t1_wd", rf_wd, 32'h1234);
        chk("t1_retire", retire, 1'b1); chk("t1_cnt", ret_cnt, 32'd1);

        set_op(5'd9, RFW_NPC, 32'h1C000); in_rf_wrsel = 1'b1;
        cyc();
        chk("t2_bl_wr", rf_wr, 5'd1); chk("t2_bl_wd", rf_wd, 32'h1C004);
        for (int i = 0; i < 4; i++) begin
            set_op(5'(10 + i), RFW_ALUC, 32'h100 + i);
            cyc();
            chk("t2_b2b_we", rf_we, 1'b1); chk("t2_b2b_wr", rf_wr, 5'(10 + i));
        end
        chk("t2_cnt", ret_cnt, 32'd6);
        set_op(5'd2, RFW_SEXT, 32'h0000FFFF);
        cyc(); clr();
        chk("t2_sext_wd", rf_wd, 32'hFFFF0000);

        for (int i = 0; i < 7; i++) do_load(lt[i], llo[i], lrd[i], lw[i], lx[i]);
        chk("t3_cnt", ret_cnt, 32'd14);

        set_op(5'd0, RFW_ALUC, 32'hDEAD);
        cyc(); clr();
        chk("t4_r0_we", rf_we, 1'b0); chk("t4_r0_retire", retire, 1'b1);
        chk("t4_hold_wr", rf_wr, 5'd15); chk("t4_hold_wd", rf_wd, 32'h7F);

        dram_rvalid = 1; dram_rdata = 32'h99;
        cyc(); clr();
        chk("idle_rvalid_we", rf_we, 1'b0); chk("idle_rvalid_ret", retire, 1'b0);

        set_op(5'd9, RFW_DRAM, 32'h0); in_ld_type = LD_W;
        cyc(); clr();
        chk("t5_pending", ld_pending, 1'b1);
        flush = 1; dram_rvalid = 1; dram_rdata = 32'h1111;
        cyc(); clr();
        chk("t5_fl_we", rf_we, 1'b0); chk("t5_fl_ret", retire, 1'b0);
        chk("t5_fl_ready", in_ready, 1'b1);
        set_op(5'd4, RFW_ALUC, 32'h4444); flush = 1;
        cyc(); clr();
        chk("t5_fl_idle_we", rf_we, 1'b0); chk("t5_fl_idle_ret", retire, 1'b0);
        chk("t5_cnt", ret_cnt, 32'd15);

        set_op(5'd6, RFW_DRAM, 32'h0); in_ld_type = LD_B;
        cyc(); clr();
        #2 rst_n = 0;
        #1;
        chk("t6_rst_pending", ld_pending, 1'b0); chk("t6_rst_ld_rd", ld_rd, 5'd0);
        chk("t6_rst_wr", rf_wr, 5'd0); chk("t6_rst_wd", rf_wd, 32'd0);
        chk("t6_rst_cnt", ret_cnt, 32'd0); chk("t6_rst_ready", in_ready, 1'b1);
        cyc();
        rst_n = 1;
        for (int i = 0; i < 17; i++) begin
            set_op(5'd20, RFW_ALUC, 32'(i));
            cyc();
        end
        clr();
        chk("t6_cnt32", ret_cnt, 32'd17);
        chk("t6_cnt4_wrap", ret_cnt4, 4'd1);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
